// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and defaults for the interrupt entry / RTI sequencer.
// The vector sits at VECTOR_ADDR (high word) and VECTOR_ADDR+1 (low word).
package interrupt_sequencer_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int PC_WIDTH_DEF   = 32;
  localparam int FLAG_WIDTH_DEF = 4;
  localparam int VECTOR_ADDR    = 0;

  typedef enum logic [3:0] {
    IDLE,
    FLUSH,
    PUSH_HI,
    PUSH_LO,
    PUSH_FL,
    VEC_HI,
    VEC_LO,
    JUMP,
    POP_SETUP,
    POP_FL,
    POP_LO,
    POP_HI,
    RESUME
  } state_e;
endpackage

// File: rtl/interrupt_sequencer_if.sv
// Stack/vector memory port owned by the sequencer while it is busy.
// master = sequencer side, slave = memory side.
interface interrupt_sequencer_if
  import interrupt_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  mem_req;
  logic                  mem_we;
  logic                  mem_vec;
  logic                  mem_vec_off;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_vec, mem_vec_off, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_vec, mem_vec_off, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/interrupt_sequencer_seq_mem_port.sv
// Request/ack front end: holds the access until acked, inserts one turnaround
// cycle after every ack so SP settles, and produces the sp_dec/sp_inc pulses.
module seq_mem_port
  import interrupt_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic                  vec_i,
  input  logic                  vec_off_i,
  input  logic                  setup_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  xfer_o,
  output logic                  sp_dec_o,
  output logic                  sp_inc_o,
  interrupt_sequencer_if.master mem
);
  logic gap_q, gap_d;
  logic sp_dec_q, sp_dec_d;

  // The request stays up (with its attributes) until the ack cycle.
  assign mem.mem_req     = req_i & ~gap_q;
  assign mem.mem_we      = mem.mem_req & we_i;
  assign mem.mem_vec     = mem.mem_req & vec_i;
  assign mem.mem_vec_off = mem.mem_req & vec_off_i;
  assign mem.mem_wdata   = (mem.mem_req & we_i) ? wdata_i : '0;

  assign xfer_o   = mem.mem_req & mem.mem_ack;
  assign gap_d    = xfer_o;
  assign sp_dec_d = xfer_o & we_i;

  assign sp_dec_o = sp_dec_q;
  // A pending stack read uses the turnaround cycle to bump SP ahead of itself.
  assign sp_inc_o = setup_i | (gap_q & req_i & ~we_i & ~vec_i);

  always_ff @(posedge clk) begin
    if (!reset) begin
      gap_q    <= 1'b0;
      sp_dec_q <= 1'b0;
    end else begin
      gap_q    <= gap_d;
      sp_dec_q <= sp_dec_d;
    end
  end
endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry (flush, push PC/flags, fetch vector, jump) and RTI return
// (pop flags/PC, resume) controller for the pipelined core.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int PC_WIDTH     = PC_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int FLAG_WIDTH   = FLAG_WIDTH_DEF,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  int_in,
  input  logic                  stall,
  input  logic                  rti_in,
  input  logic [PC_WIDTH-1:0]   pc_in,
  input  logic [FLAG_WIDTH-1:0] flags_in,
  interrupt_sequencer_if.master mem,
  output logic                  sp_dec,
  output logic                  sp_inc,
  output logic                  pipe_freeze,
  output logic                  pipe_flush,
  output logic                  pc_load,
  output logic [PC_WIDTH-1:0]   pc_load_val,
  output logic                  flags_load,
  output logic [FLAG_WIDTH-1:0] flags_load_val,
  output logic                  int_ack,
  output logic                  busy
);
  state_e                  state_q, state_d;
  logic                    pending_q, pending_d;
  logic [DRAIN_CYCLES-1:0] drain_q, drain_d;
  logic [PC_WIDTH-1:0]     saved_pc_q;
  logic [FLAG_WIDTH-1:0]   saved_fl_q, pop_fl_q;
  logic [DATA_WIDTH-1:0]   hi_q, lo_q;

  logic                  accept, xfer;
  logic                  req, we, vec, vec_off, setup;
  logic [DATA_WIDTH-1:0] wdata;

  assign accept    = (state_q == IDLE) & ~rti_in & (pending_q | int_in) & ~stall;
  assign pending_d = accept ? 1'b0 : (pending_q | int_in);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    req            = 1'b0;
    we             = 1'b0;
    vec            = 1'b0;
    vec_off        = 1'b0;
    setup          = 1'b0;
    wdata          = '0;
    pipe_freeze    = (state_q != IDLE);
    pipe_flush     = 1'b0;
    pc_load        = 1'b0;
    pc_load_val    = '0;
    flags_load     = 1'b0;
    flags_load_val = '0;
    int_ack        = 1'b0;
    case (state_q)
      IDLE: begin
        drain_d = DRAIN_CYCLES'(1);
        if (rti_in)      state_d = POP_SETUP;
        else if (accept) state_d = FLUSH;
      end
      FLUSH: begin
        // One-hot walker: bit 0 marks the first flush cycle, MSB the last.
        pipe_flush = 1'b1;
        int_ack    = drain_q[0];
        drain_d    = drain_q << 1;
        if (drain_q[DRAIN_CYCLES-1]) state_d = PUSH_HI;
      end
      PUSH_HI: begin
        req   = 1'b1;
        we    = 1'b1;
        wdata = saved_pc_q[PC_WIDTH-1 -: DATA_WIDTH];
        if (xfer) state_d = PUSH_LO;
      end
      PUSH_LO: begin
        req   = 1'b1;
        we    = 1'b1;
        wdata = saved_pc_q[DATA_WIDTH-1:0];
        if (xfer) state_d = PUSH_FL;
      end
      PUSH_FL: begin
        req   = 1'b1;
        we    = 1'b1;
        wdata = DATA_WIDTH'(saved_fl_q);
        if (xfer) state_d = VEC_HI;
      end
      VEC_HI: begin
        req = 1'b1;
        vec = 1'b1;
        if (xfer) state_d = VEC_LO;
      end
      VEC_LO: begin
        req     = 1'b1;
        vec     = 1'b1;
        vec_off = 1'b1;
        if (xfer) state_d = JUMP;
      end
      JUMP: begin
        pc_load     = 1'b1;
        pc_load_val = {hi_q, lo_q};
        state_d     = IDLE;
      end
      POP_SETUP: begin
        setup   = 1'b1;
        state_d = POP_FL;
      end
      POP_FL: begin
        req = 1'b1;
        if (xfer) state_d = POP_LO;
      end
      POP_LO: begin
        req = 1'b1;
        if (xfer) state_d = POP_HI;
      end
      POP_HI: begin
        req = 1'b1;
        if (xfer) state_d = RESUME;
      end
      RESUME: begin
        pc_load        = 1'b1;
        pc_load_val    = {hi_q, lo_q};
        flags_load     = 1'b1;
        flags_load_val = pop_fl_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      drain_q    <= '0;
      saved_pc_q <= '0;
      saved_fl_q <= '0;
      pop_fl_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      drain_q   <= drain_d;
      if (accept) begin
        saved_pc_q <= pc_in;
        saved_fl_q <= flags_in;
      end
      // Vector fetch and PC pops share the hi/lo holding registers.
      if (xfer) begin
        case (state_q)
          VEC_HI, POP_HI: hi_q     <= mem.mem_rdata;
          VEC_LO, POP_LO: lo_q     <= mem.mem_rdata;
          POP_FL:         pop_fl_q <= mem.mem_rdata[FLAG_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  seq_mem_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .we_i      (we),
    .vec_i     (vec),
    .vec_off_i (vec_off),
    .setup_i   (setup),
    .wdata_i   (wdata),
    .xfer_o    (xfer),
    .sp_dec_o  (sp_dec),
    .sp_inc_o  (sp_inc),
    .mem       (mem)
  );
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench: entry timing, stall deferral, wait states, RTI, collision
// and mid-sequence reset, with hand-computed per-cycle event masks.
module tb_interrupt_sequencer;
  import interrupt_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, int_in, stall, rti_in, ack_r, log_clr;
  logic [31:0] pc_in, pc_load_val;
  logic [3:0]  flags_in, flags_load_val;
  logic        sp_dec, sp_inc, pipe_freeze, pipe_flush, pc_load, flags_load, int_ack, busy;

  logic [15:0] mem_img [0:3];
  logic [15:0] pop_words [0:2];
  int          pop_idx;
  logic [15:0] wlog [$];
  int          n_chk = 0;
  int          n_pass = 0;

  logic [15:0] tr_busy, tr_req, tr_we, tr_spd, tr_spi, tr_ack, tr_flush, tr_pcl;
  logic [31:0] ld_pc;
  logic [3:0]  ld_fl;
  logic        ld_fll;

  interrupt_sequencer_if #(.DATA_WIDTH(16)) mif ();

  assign mif.mem_ack   = ack_r;
  assign mif.mem_rdata = mif.mem_vec ? mem_img[VECTOR_ADDR + int'(mif.mem_vec_off)]
                       : (pop_idx < 3 ? pop_words[pop_idx] : 16'hDEAD);

  interrupt_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .int_in         (int_in),
    .stall          (stall),
    .rti_in         (rti_in),
    .pc_in          (pc_in),
    .flags_in       (flags_in),
    .mem            (mif),
    .sp_dec         (sp_dec),
    .sp_inc         (sp_inc),
    .pipe_freeze    (pipe_freeze),
    .pipe_flush     (pipe_flush),
    .pc_load        (pc_load),
    .pc_load_val    (pc_load_val),
    .flags_load     (flags_load),
    .flags_load_val (flags_load_val),
    .int_ack        (int_ack),
    .busy           (busy)
  );

  // Memory-side log: pushed words in order, and a pop pointer for reads at SP.
  always @(posedge clk) begin
    if (log_clr) begin
      wlog.delete();
      pop_idx <= 0;
    end else if (mif.mem_req && mif.mem_ack) begin
      if (mif.mem_we)        wlog.push_back(mif.mem_wdata);
      else if (!mif.mem_vec) pop_idx <= pop_idx + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic clr_logs();
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
  endtask

  task automatic run_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  // Bit k of each mask is the output seen in the (k+1)th cycle after the stimulus cycle.
  task automatic trace(input int n);
    tr_busy = '0; tr_req = '0; tr_we = '0; tr_spd = '0;
    tr_spi = '0; tr_ack = '0; tr_flush = '0; tr_pcl = '0;
    ld_pc = '0; ld_fl = '0; ld_fll = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      int_in = 1'b0;
      rti_in = 1'b0;
      tr_busy[k]  = busy;
      tr_req[k]   = mif.mem_req;
      tr_we[k]    = mif.mem_we;
      tr_spd[k]   = sp_dec;
      tr_spi[k]   = sp_inc;
      tr_ack[k]   = int_ack;
      tr_flush[k] = pipe_flush;
      tr_pcl[k]   = pc_load;
      if (pc_load) begin
        ld_pc  = pc_load_val;
        ld_fl  = flags_load_val;
        ld_fll = flags_load;
      end
    end
  endtask

  initial begin
    logic bad, hold;
    int   spd;
    reset = 1'b0; int_in = 1'b0; stall = 1'b0; rti_in = 1'b0;
    ack_r = 1'b1; log_clr = 1'b0; pc_in = '0; flags_in = '0;
    mem_img[0] = 16'h0000; mem_img[1] = 16'h0000; mem_img[2] = 16'h0000; mem_img[3] = 16'h0000;
    mem_img[VECTOR_ADDR]     = 16'h0000;
    mem_img[VECTOR_ADDR + 1] = 16'h0100;
    pop_words[0] = 16'h000A; pop_words[1] = 16'h2345; pop_words[2] = 16'h0001;

    repeat (2) @(negedge clk);
    chk("rst_ctl", {busy, pipe_freeze, pipe_flush, int_ack, sp_dec, sp_inc, pc_load, flags_load,
                    mif.mem_req, mif.mem_we, mif.mem_vec, mif.mem_vec_off}, 64'd0);
    chk("rst_vals", {pc_load_val, flags_load_val, mif.mem_wdata}, 64'd0);
    chk("rst_pending", {63'd0, dut.pending_q}, 64'd0);
    reset = 1'b1;
    clr_logs();

    // Basic entry with zero wait states
    pc_in = 32'h0001_2345; flags_in = 4'b1010; int_in = 1'b1;
    trace(15);
    chk("ent_int_ack", tr_ack,   16'h0001);
    chk("ent_flush",   tr_flush, 16'h0007);
    chk("ent_req",     tr_req,   16'h0AA8);
    chk("ent_sp_dec",  tr_spd,   16'h0150);
    chk("ent_sp_inc",  tr_spi,   16'h0000);
    chk("ent_pc_load", tr_pcl,   16'h1000);
    chk("ent_busy",    tr_busy,  16'h1FFF);
    chk("ent_pc_val",  ld_pc,    32'h0000_0100);
    chk("ent_nwr",     wlog.size(), 3);
    chk("ent_wdata",   {wlog[0], wlog[1], wlog[2]}, 48'h0001_2345_000A);
    clr_logs();

    // Stall deferral
    stall = 1'b1; int_in = 1'b1; bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      int_in = 1'b0;
      bad = bad | busy | int_ack;
    end
    chk("stl_idle",    {63'd0, bad}, 64'd0);
    chk("stl_pending", {63'd0, dut.pending_q}, 64'd1);
    stall = 1'b0;
    @(negedge clk);
    chk("stl_go", {pipe_flush, int_ack, busy}, 3'b111);
    run_idle();
    clr_logs();

    // Three wait states on PUSH_LO
    int_in = 1'b1;
    repeat (6) begin
      @(negedge clk);
      int_in = 1'b0;
    end
    hold = 1'b1; spd = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      hold = hold & mif.mem_req & mif.mem_we & ~mif.mem_vec & (mif.mem_wdata == 16'h2345);
      spd += int'(sp_dec);
      ack_r = (i == 3);
    end
    @(negedge clk);
    spd += int'(sp_dec);
    chk("ws_hold",   {63'd0, hold}, 64'd1);
    chk("ws_sp_dec", spd, 1);
    run_idle();
    chk("ws_wdata", {wlog[0], wlog[1], wlog[2]}, 48'h0001_2345_000A);
    clr_logs();

    // RTI round trip
    rti_in = 1'b1;
    trace(8);
    chk("rti_busy",   tr_busy, 16'h007F);
    chk("rti_sp_inc", tr_spi,  16'h0015);
    chk("rti_req",    tr_req,  16'h002A);
    chk("rti_we",     tr_we | tr_spd | tr_flush, 16'h0000);
    chk("rti_load",   tr_pcl,  16'h0040);
    chk("rti_pc_val", ld_pc,   32'h0001_2345);
    chk("rti_fl",     {ld_fll, ld_fl}, 5'b1_1010);
    clr_logs();

    // int_in and rti_in together: RTI first, interrupt taken from the following IDLE
    pc_in = 32'h0000_ABCD; flags_in = 4'b0101; int_in = 1'b1; rti_in = 1'b1;
    trace(10);
    chk("col_busy",    tr_busy, 16'h037F);
    chk("col_int_ack", tr_ack,  16'h0100);
    chk("col_load",    tr_pcl,  16'h0040);
    chk("col_pc_val",  ld_pc,   32'h0001_2345);
    run_idle();
    chk("col_wdata", {wlog[0], wlog[1], wlog[2]}, 48'h0000_ABCD_0005);
    clr_logs();

    // Reset while PUSH_LO is requesting
    int_in = 1'b1;
    repeat (6) begin
      @(negedge clk);
      int_in = 1'b0;
    end
    chk("rm_pre", {63'd0, mif.mem_req}, 64'd1);
    reset = 1'b0; int_in = 1'b1;
    @(negedge clk);
    chk("rm_outs", {busy, mif.mem_req, sp_dec, sp_inc, pipe_freeze}, 5'b0);
    chk("rm_pending", {63'd0, dut.pending_q}, 64'd0);
    reset = 1'b1; int_in = 1'b0;
    trace(4);
    chk("rm_quiet", tr_busy | tr_req | tr_spd | tr_spi, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Multi-cycle controller that sequences interrupt entry and RTI return for the pipelined processor.
- Sits after the interrupt deferral logic, which releases the interrupt only when the pipeline is not stalled.
- On an accepted interrupt it freezes and flushes the pipeline, pushes PC and flags to the stack, fetches the vector and redirects the PC.
- On RTI it pops flags and PC and resumes.
- It owns the stack memory port while busy.

Parameters:
- PC_WIDTH, 32, program counter width; must equal 2*DATA_WIDTH.
- DATA_WIDTH, 16, memory word width.
- FLAG_WIDTH, 4, condition flag width (Z, N, C, V).
- DRAIN_CYCLES, 3, FLUSH cycles needed to empty the in-flight stages; must be ≥1.
- VECTOR_ADDR, 0, memory address of the vector high word; the low word is at VECTOR_ADDR+1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- int_in  in  1  interrupt request pulse, already stall-qualified upstream.
- stall  in  1  pipeline stall.
- rti_in  in  1  RTI decoded in the execute stage; one-cycle pulse.
- pc_in  in  PC_WIDTH  return PC to save on interrupt entry.
- flags_in  in  FLAG_WIDTH  current flags.
- mem_req  out  1  memory request; held until acked.
- mem_we  out  1  1 = write (push), 0 = read (pop/vector).
- mem_vec  out  1  1 = address is VECTOR_ADDR+mem_vec_off, 0 = address is SP.
- mem_vec_off  out  1  vector word select.
- mem_wdata  out  DATA_WIDTH  push data.
- mem_rdata  in  DATA_WIDTH  read data; valid in the ack cycle.
- mem_ack  in  1  transfer completes in this cycle.
- sp_dec  out  1  one-cycle pulse after each push is acked.
- sp_inc  out  1  one-cycle pulse before each pop, issued in the cycle preceding mem_req.
- pipe_freeze  out  1  hold fetch/decode.
- pipe_flush  out  1  bubble the stages in flight.
- pc_load  out  1  one-cycle PC redirect.
- pc_load_val  out  PC_WIDTH  redirect target.
- flags_load  out  1  one-cycle flag restore.
- flags_load_val  out  FLAG_WIDTH  restored flags.
- int_ack  out  1  one-cycle pulse when an interrupt is accepted.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, pending=0.
  - All outputs are 0, including pc_load_val and flags_load_val.
  - Reset mid-sequence aborts it immediately; no further memory request or sp pulse is issued.
- Pending latch:
  - int_in=1 sets pending in any state.
  - pending clears when the interrupt is accepted (int_ack).
  - A second int_in while pending=1 is merged; the pending latch is one deep.
- IDLE:
  - rti_in=1 has priority → POP_SETUP.
  - Else if (pending|int_in) and stall=0 → FLUSH, with int_ack=1 in the first FLUSH cycle.
  - On acceptance, pc_in and flags_in are captured into save registers at the same edge.
  - If stall=1, wait in IDLE with pending held.
- FLUSH:
  - pipe_freeze=1 and pipe_flush=1 for exactly DRAIN_CYCLES cycles, then → PUSH_HI.
- pipe_freeze stays 1 in every state except IDLE.
- PUSH_HI, PUSH_LO, PUSH_FL:
  - Each state drives mem_req=1, mem_we=1, mem_vec=0.
  - mem_wdata is saved_pc[31:16], saved_pc[15:0], and zero-extended saved_flags respectively.
  - Each state waits for mem_ack; mem_req, address and data are held stable until then.
  - The ack cycle advances the state and pulses sp_dec in the next cycle.
- VEC_HI, VEC_LO:
  - Read with mem_vec=1, mem_vec_off=0 then 1.
  - mem_rdata is captured into the target register on ack.
- JUMP: pc_load=1 and pc_load_val=target for one cycle → IDLE.
- POP_SETUP: sp_inc=1 for one cycle → POP_FL.
- POP_FL, POP_LO, POP_HI:
  - Each state reads at SP and captures data on ack.
  - After POP_FL and POP_LO acks, one sp_inc cycle precedes the next read.
  - POP order is the reverse of push.
- RESUME:
  - pc_load=1 with {hi,lo}, and flags_load=1 with popped[FLAG_WIDTH-1:0], both for one cycle → IDLE.
- Interrupt arriving during an RTI sequence: stays pending and is taken from IDLE after RESUME, subject to stall.
- rti_in during an interrupt sequence: ignored, since the pipeline is frozen.
- Latency, with mem_ack tied to 1 and DRAIN_CYCLES=3:
  - int_in at cycle t: FLUSH t+1..t+3, PUSH_HI t+4, sp_dec t+5.
  - Entry completes with pc_load at cycle t+13 (see the entry test); pc_load_val = vector.
- Width rules: no arithmetic inside the block; SP arithmetic lives in the register file via sp_dec/sp_inc.

Decomposition:
- Shared package holds:
  - the state enumeration (IDLE, FLUSH, PUSH_HI, PUSH_LO, PUSH_FL, VEC_HI, VEC_LO, JUMP, POP_SETUP, POP_FL, POP_LO, POP_HI, RESUME);
  - DATA_WIDTH, PC_WIDTH and FLAG_WIDTH defaults;
  - VECTOR_ADDR.
- One natural sub-module: seq_mem_port, which holds the req/ack request and its stable address/data until ack, and generates the sp_dec/sp_inc pulses.

Test Plan:
- Basic entry:
  - Stimulus: reset low 2 cycles then high; mem_ack=1; int_in pulse at t with pc_in=0x0001_2345, flags_in=0b1010; vector memory = 0x0000_0100.
  - Response: writes 0x0001, 0x2345, 0x000A in order; sp_dec×3; pc_load at t+13 with pc_load_val=0x0000_0100; int_ack only at t+1.
- Stall deferral:
  - Stimulus: int_in with stall=1 for 5 cycles.
  - Response: stays IDLE, pending=1, no int_ack; after stall drops, FLUSH starts the next cycle.
- Wait states:
  - Stimulus: mem_ack delayed 3 cycles on PUSH_LO.
  - Response: mem_wdata=0x2345 and mem_req held constant all 4 cycles; exactly one sp_dec.
- RTI round trip:
  - Stimulus: run the basic entry, then rti_in; pop data returns 0x000A, 0x2345, 0x0001.
  - Response: sp_inc precedes each read; RESUME gives pc_load_val=0x0001_2345, flags_load_val=0b1010.
- Collision:
  - Stimulus: int_in and rti_in in the same IDLE cycle.
  - Response: RTI sequence runs first; the interrupt is accepted the cycle after RESUME.
- Reset mid-sequence:
  - Stimulus: reset=0 during PUSH_LO.
  - Response: next cycle busy=0, mem_req=0, pending=0, no sp pulses.
